io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
Parametrised multi-channel memory-mapped I/O port bank. It is the successor to the single-channel store/load data port.
- Adds CHANNELS independent 32-bit ports.
- Stores merge into the selected byte/halfword lane.
- Loads sign- or zero-extend the selected lane.
- Inputs pass through a multi-flop synchroniser with a per-channel sticky change flag and a maskable interrupt.
- Misaligned and illegal accesses are detected and suppressed.

The block sits between the CPU load/store unit and external pins.

Parameters:
- CHANNELS, 4: number of 32-bit I/O channels (1..16).
- SYNC_STAGES, 2: synchroniser flops per input channel (2..4).
- CH_W, max(1,$clog2(CHANNELS)): channel-select width (derived, localparam).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- store  in  1  write cpu_in into the selected channel output register this cycle.
- load  in  1  capture the synchronised input of the selected channel this cycle.
- channel  in  CH_W  channel select for store/load/cpu_out.
- data_type  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- data_offset  in  2  byte offset within the word.
- cpu_in  in  32  store data; least-significant bits are used for B/H.
- io_in  in  CHANNELS*32  external inputs; channel c is bits [c*32+31:c*32], asynchronous.
- irq_mask  in  CHANNELS  per-channel interrupt enable.
- cpu_out  out  32  extended load data from the captured input register of the selected channel.
- io_out  out  CHANNELS*32  output registers, same packing as io_in.
- changed  out  CHANNELS  sticky input-change flags.
- irq  out  1  OR of (changed & irq_mask).
- access_error  out  1  one-cycle registered pulse on a rejected access.

Behaviour:
- Reset (async, reset_n=0): every register clears to 0, so the following are all 0:
  - io_out, input capture registers, synchroniser chains, prev registers, changed, irq, access_error, cpu_out.
- Synchroniser (per channel): an io_in change appears in the synced value s[c] after SYNC_STAGES clocks.
- prev[c] <= s[c] every cycle.
- Change detection: if s[c] != prev[c], changed[c] is set on the next edge.
  - A legal load of channel c clears changed[c].
  - If set and clear happen in the same cycle, set wins.
- Legality: an access (store or load) is legal only if all of the following hold:
  - channel < CHANNELS;
  - data_type is in {000,001,010,100,101};
  - H/HU use data_offset in {0,2};
  - W uses data_offset 0.
  Loads check the full type set; stores accept only 000/001/010, so 100/101 on a store are illegal.
- Illegal access:
  - No register update and no flag clear.
  - access_error=1 in the following cycle, for exactly one cycle.
  - If store and load are both asserted and either is illegal, neither is performed.
- Store (legal): updates output register channel on the edge; other lanes are retained.
  - B: lane data_offset <= cpu_in[7:0].
  - H: lanes offset, offset+1 <= cpu_in[15:0].
  - W: full word.
  - io_out reflects the new value the cycle after.
- Load (legal): input_reg[channel] <= s[channel] on the edge.
  - cpu_out is combinational from input_reg[channel], data_type and data_offset, so data is valid from the cycle after load.
  - B: sign-extend byte; BU: zero-extend byte; H: sign-extend half; HU: zero-extend half; W: full word.
  - cpu_out = 0 for any combination that would be illegal.
- Simultaneous store and load (legal): both are performed. Load captures the synced external input, never io_out.
- Mid-operation reset clears all registers immediately (async). The first legal access after deassertion behaves as from reset.
- irq is combinational from the changed register and irq_mask, with no extra latency.

Decomposition:
- Package io_pkg holds:
  - enum access_t (ACC_B=3'b000, ACC_H=3'b001, ACC_W=3'b010, ACC_BU=3'b100, ACC_HU=3'b101);
  - function is_legal(type, offset, is_store);
  - function extend_lane(word, type, offset);
  - function merge_lane(old, new, type, offset).
- Sub-module io_sync_channel: SYNC_STAGES synchroniser, prev register and the changed flag with set/clear priority. It is instantiated CHANNELS times via generate.

Test Plan:
- Reset, then store W 0xDEADBEEF on ch2; next cycle store B 0x11 at offset 1 on ch2 -> io_out ch2 = 0xDEAD11EF; all other channels stay 0.
- Drive io_in ch1 = 0x0000_80F0, wait SYNC_STAGES+1 cycles, load ch1 -> next cycle:
  - H off0: cpu_out = 0xFFFF80F0;
  - HU: cpu_out = 0x000080F0;
  - B off1: cpu_out = 0xFFFFFF80;
  - BU off0: cpu_out = 0x000000F0.
- io_in ch3 toggles with irq_mask=4'b1000 -> changed[3] and irq rise SYNC_STAGES+1 cycles after the toggle. Load ch3 clears both; a new toggle during the clearing load keeps changed[3]=1.
- Store H at offset 1 on ch0 -> io_out unchanged, access_error=1 for one cycle. Load W at offset 2 -> input_reg unchanged, cpu_out=0.
- Simultaneous store W 0x12345678 and load on ch0 with io_in ch0 = 0xCAFEF00D (stable) -> io_out ch0 = 0x12345678, cpu_out (W) = 0xCAFEF00D.
- Assert reset_n=0 mid-sequence between clock edges -> io_out, changed, irq and cpu_out go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_pkg.sv
// Shared access-type encoding and lane helpers for the I/O port bank.
package io_pkg;

  typedef enum logic [2:0] {
    ACC_B  = 3'b000,
    ACC_H  = 3'b001,
    ACC_W  = 3'b010,
    ACC_BU = 3'b100,
    ACC_HU = 3'b101
  } access_t;

  // Stores only accept B/H/W; halves must sit on a halfword boundary and
  // words on offset 0.
  function automatic logic is_legal(input logic [2:0] dtype,
                                    input logic [1:0] offset,
                                    input logic       is_store);
    logic ok;
    ok = 1'b0;
    case (dtype)
      ACC_B:   ok = 1'b1;
      ACC_BU:  ok = !is_store;
      ACC_H:   ok = !offset[0];
      ACC_HU:  ok = !is_store && !offset[0];
      ACC_W:   ok = (offset == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Selects and extends the addressed lane; illegal combinations read as 0.
  function automatic logic [31:0] extend_lane(input logic [31:0] word,
                                              input logic [2:0]  dtype,
                                              input logic [1:0]  offset);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    res = '0;
    case (offset)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = offset[1] ? word[31:16] : word[15:0];
    if (is_legal(dtype, offset, 1'b0)) begin
      case (dtype)
        ACC_B:   res = {{24{byte_v[7]}}, byte_v};
        ACC_BU:  res = {24'd0, byte_v};
        ACC_H:   res = {{16{half_v[15]}}, half_v};
        ACC_HU:  res = {16'd0, half_v};
        ACC_W:   res = word;
        default: res = '0;
      endcase
    end
    return res;
  endfunction

  // Writes the low bits of new_w into the addressed lane, keeping the rest.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [2:0]  dtype,
                                             input logic [1:0]  offset);
    logic [31:0] res;
    res = old_w;
    case (dtype)
      ACC_B: begin
        case (offset)
          2'd0:    res[7:0]   = new_w[7:0];
          2'd1:    res[15:8]  = new_w[7:0];
          2'd2:    res[23:16] = new_w[7:0];
          default: res[31:24] = new_w[7:0];
        endcase
      end
      ACC_H: begin
        if (offset[1]) res[31:16] = new_w[15:0];
        else           res[15:0]  = new_w[15:0];
      end
      ACC_W:   res = new_w;
      default: res = old_w;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/io_sync_channel.sv
// One input channel: synchroniser chain, previous-value register and the
// sticky change flag.
module io_sync_channel #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] io_in,
  input  logic        clear,
  output logic [31:0] synced,
  output logic        changed
);

  logic [31:0] chain [SYNC_STAGES];
  logic [31:0] prev;

  assign synced = chain[SYNC_STAGES-1];

  // Shift the asynchronous input through the chain, track the last synced
  // value and keep the change flag; a new change beats a clearing load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev    <= '0;
      changed <= 1'b0;
    end else begin
      chain[0] <= io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= synced;
      if (synced != prev)  changed <= 1'b1;
      else if (clear)      changed <= 1'b0;
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Multi-channel memory-mapped I/O port bank with lane merge/extend,
// synchronised inputs, change flags and access checking.
module io_port_bank
  import io_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  store,
  input  logic                  load,
  input  logic [CH_W-1:0]       channel,
  input  logic [2:0]            data_type,
  input  logic [1:0]            data_offset,
  input  logic [31:0]           cpu_in,
  input  logic [CHANNELS*32-1:0] io_in,
  input  logic [CHANNELS-1:0]   irq_mask,
  output logic [31:0]           cpu_out,
  output logic [CHANNELS*32-1:0] io_out,
  output logic [CHANNELS-1:0]   changed,
  output logic                  irq,
  output logic                  access_error
);

  logic [31:0] out_reg   [CHANNELS];
  logic [31:0] input_reg [CHANNELS];
  logic [31:0] synced    [CHANNELS];
  logic        ch_ok, store_ok, load_ok, do_store, do_load, reject;

  assign ch_ok    = (32'(channel) < CHANNELS);
  assign store_ok = ch_ok && is_legal(data_type, data_offset, 1'b1);
  assign load_ok  = ch_ok && is_legal(data_type, data_offset, 1'b0);

  // A paired store+load is all-or-nothing: one illegal half cancels both.
  assign reject   = (store && !store_ok) || (load && !load_ok);
  assign do_store = store && !reject;
  assign do_load  = load  && !reject;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    io_sync_channel #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .io_in   (io_in[c*32 +: 32]),
      .clear   (do_load && (channel == CH_W'(c))),
      .synced  (synced[c]),
      .changed (changed[c])
    );
    assign io_out[c*32 +: 32] = out_reg[c];
  end

  // Output registers take merged store data; capture registers take the
  // synced input on a load; rejected accesses raise a one-cycle error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        out_reg[i]   <= '0;
        input_reg[i] <= '0;
      end
      access_error <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (do_store && (channel == CH_W'(i)))
          out_reg[i] <= merge_lane(out_reg[i], cpu_in, data_type, data_offset);
        if (do_load && (channel == CH_W'(i)))
          input_reg[i] <= synced[i];
      end
      access_error <= reject;
    end
  end

  // Extended read of the captured input for the selected channel.
  always_comb begin
    cpu_out = '0;
    if (ch_ok) cpu_out = extend_lane(input_reg[channel], data_type, data_offset);
  end

  assign irq = |(changed & irq_mask);

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         store, load;
  logic [1:0]   channel;
  logic [2:0]   data_type;
  logic [1:0]   data_offset;
  logic [31:0]  cpu_in;
  logic [127:0] io_in;
  logic [3:0]   irq_mask;
  logic [31:0]  cpu_out;
  logic [127:0] io_out;
  logic [3:0]   changed;
  logic         irq;
  logic         access_error;

  int total = 0;
  int bad   = 0;

  io_port_bank #(.CHANNELS(4), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .store        (store),
    .load         (load),
    .channel      (channel),
    .data_type    (data_type),
    .data_offset  (data_offset),
    .cpu_in       (cpu_in),
    .io_in        (io_in),
    .irq_mask     (irq_mask),
    .cpu_out      (cpu_out),
    .io_out       (io_out),
    .changed      (changed),
    .irq          (irq),
    .access_error (access_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    store = 1'b0;
    load  = 1'b0;
  endtask

  task automatic access(input logic st, input logic ld, input logic [1:0] ch,
                        input logic [2:0] dt, input logic [1:0] off, input logic [31:0] d);
    store = st; load = ld; channel = ch; data_type = dt; data_offset = off; cpu_in = d;
  endtask

  initial begin
    reset_n = 1'b0; idle(); channel = '0; data_type = '0; data_offset = '0;
    cpu_in = '0; io_in = '0; irq_mask = '0;
    #3;
    check("rst_io_out", io_out, '0);
    check("rst_changed", changed, '0);
    check("rst_irq", irq, 0);
    check("rst_err", access_error, 0);
    check("rst_cpu_out", cpu_out, '0);
    #9 reset_n = 1'b1;
    tick();

    // word store then byte merge on channel 2
    access(1, 0, 2, 3'b010, 0, 32'hDEADBEEF); tick();
    check("st_w", io_out[95:64], 32'hDEADBEEF);
    access(1, 0, 2, 3'b000, 1, 32'hFFFFFF11); tick(); idle();
    check("st_b_merge", io_out[95:64], 32'hDEAD11EF);
    check("other_lo", io_out[63:0], '0);
    check("other_hi", io_out[127:96], '0);

    // load channel 1 and read it back with each extension
    io_in[63:32] = 32'h000080F0;
    tick(); tick(); tick();
    check("ch1_changed", changed[1], 1);
    access(0, 1, 1, 3'b001, 0, 0); tick(); idle();
    check("ld_h", cpu_out, 32'hFFFF80F0);
    check("ld_clears", changed[1], 0);
    data_type = 3'b101; #1 check("ld_hu", cpu_out, 32'h000080F0);
    data_type = 3'b000; data_offset = 1; #1 check("ld_b1", cpu_out, 32'hFFFFFF80);
    data_type = 3'b100; data_offset = 0; #1 check("ld_bu0", cpu_out, 32'h000000F0);
    data_type = 3'b010; data_offset = 2; #1 check("ld_w_off2_zero", cpu_out, '0);
    data_type = 3'b011; data_offset = 0; #1 check("ld_bad_type_zero", cpu_out, '0);
    tick();

    // change flag and irq on channel 3
    irq_mask = 4'b1000;
    io_in[127:96] = 32'h1;
    tick(); tick();
    check("chg3_not_yet", changed[3], 0);
    check("irq_not_yet", irq, 0);
    tick();
    check("chg3_set", changed[3], 1);
    check("irq_set", irq, 1);
    access(0, 1, 3, 3'b010, 0, 0); tick(); idle();
    check("chg3_cleared", changed[3], 0);
    check("irq_cleared", irq, 0);
    io_in[127:96] = 32'h3;
    tick(); tick();
    access(0, 1, 3, 3'b010, 0, 0); tick(); idle();
    check("set_beats_clear", changed[3], 1);
    check("irq_kept", irq, 1);
    access(0, 1, 3, 3'b010, 0, 0); tick(); idle();
    check("chg3_cleared2", changed[3], 0);

    // illegal accesses
    access(1, 0, 0, 3'b001, 1, 32'hAAAAAAAA); tick(); idle();
    check("bad_st_io_out", io_out[31:0], '0);
    check("bad_st_err", access_error, 1);
    tick();
    check("err_one_cycle", access_error, 0);
    access(1, 0, 0, 3'b100, 0, 32'hAAAAAAAA); tick(); idle();
    check("st_bu_err", access_error, 1);
    check("st_bu_io_out", io_out[31:0], '0);
    io_in[63:32] = 32'h12345678;
    tick(); tick(); tick();
    access(0, 1, 1, 3'b010, 2, 0); #1;
    check("bad_ld_cpu_out", cpu_out, '0);
    tick(); idle();
    check("bad_ld_err", access_error, 1);
    check("bad_ld_no_clear", changed[1], 1);
    data_offset = 0; #1 check("bad_ld_reg_kept", cpu_out, 32'h000080F0);

    // simultaneous legal store and load
    io_in[31:0] = 32'hCAFEF00D;
    tick(); tick(); tick();
    access(1, 1, 0, 3'b010, 0, 32'h12345678); tick(); idle();
    check("both_io_out", io_out[31:0], 32'h12345678);
    check("both_cpu_out", cpu_out, 32'hCAFEF00D);
    check("both_no_err", access_error, 0);

    // paired access with illegal store half: neither happens
    io_in[95:64] = 32'h55;
    tick(); tick(); tick();
    access(1, 1, 2, 3'b100, 0, 32'hFFFFFFFF); tick(); idle();
    check("pair_st_blocked", io_out[95:64], 32'hDEAD11EF);
    check("pair_err", access_error, 1);
    channel = 2; data_type = 3'b010; data_offset = 0;
    #1 check("pair_ld_blocked", cpu_out, '0);

    // asynchronous mid-sequence reset
    irq_mask = 4'hF; channel = 0; #1;
    check("pre_rst_irq", irq, 1);
    check("pre_rst_cpu_out", cpu_out, 32'hCAFEF00D);
    reset_n = 1'b0; #1;
    check("async_io_out", io_out, '0);
    check("async_changed", changed, '0);
    check("async_irq", irq, 0);
    check("async_cpu_out", cpu_out, '0);
    #8 reset_n = 1'b1;
    tick();
    access(1, 0, 1, 3'b010, 0, 32'hA5A5A5A5); tick(); idle();
    check("post_rst_store", io_out, {32'd0, 32'd0, 32'hA5A5A5A5, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
